// File: rtl/cpu_preload_ctrl.sv
// rtl/cpu_preload_ctrl.sv - operand preload, run control and cycle counting for the CPU demo top

// Button conditioner: 2-FF synchroniser followed by a consecutive-cycle debouncer.
module cpu_preload_debounce #(
    parameter int DEBOUNCE_CYC = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);
    localparam int CW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], raw};
        end
    end

    // Flip the debounced level only after DEBOUNCE_CYC disagreeing cycles in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (sync[1] != db) begin
            if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                db  <= ~db;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end
endmodule

// Session controller: load operands, arm, run the CPU, report cycles and timeout.
module cpu_preload_ctrl #(
    parameter int DATA_W       = 16,
    parameter int REG_W        = 32,
    parameter int NUM_ARGS     = 4,
    parameter int FIRST_REG    = 4,
    parameter int SIGN_EXT     = 0,
    parameter int DEBOUNCE_CYC = 3,
    parameter int MAX_CYC      = 1_000_000,
    parameter int CYC_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              input_press,
    input  logic              start_press,
    input  logic [DATA_W-1:0] input_num,
    input  logic              cpu_halt,
    output logic              reg_we,
    output logic [4:0]        reg_idx,
    output logic [REG_W-1:0]  reg_wdata,
    output logic              cpu_run,
    output logic [2:0]        state,
    output logic [5:0]        load_cnt,
    output logic [CYC_W-1:0]  run_cycles,
    output logic              timeout
);
    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_HOLD  = 3'd1,
        S_ARMED = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t st_q, st_n;

    logic             in_db, in_db_q, in_ev;
    logic             start_db, start_db_q, start_ev;
    logic [REG_W-1:0] ext_data;

    logic             reg_we_n;
    logic [4:0]       reg_idx_n;
    logic [REG_W-1:0] reg_wdata_n;
    logic             cpu_run_n;
    logic [5:0]       load_cnt_n;
    logic [CYC_W-1:0] run_cycles_n;
    logic             timeout_n;

    cpu_preload_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_in_db (
        .clk   (clk),
        .rst_n (rst),
        .raw   (input_press),
        .db    (in_db)
    );

    cpu_preload_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start_db (
        .clk   (clk),
        .rst_n (rst),
        .raw   (start_press),
        .db    (start_db)
    );

    // Remember last debounced levels so a press is a single-cycle rising event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_db_q    <= 1'b0;
            start_db_q <= 1'b0;
        end else begin
            in_db_q    <= in_db;
            start_db_q <= start_db;
        end
    end

    assign in_ev    = in_db & ~in_db_q;
    assign start_ev = start_db & ~start_db_q;

    // Widen the switch value to register width, sign or zero filled.
    always_comb begin
        ext_data = '0;
        ext_data[DATA_W-1:0] = input_num;
        if (SIGN_EXT != 0) begin
            for (int i = DATA_W; i < REG_W; i++) begin
                ext_data[i] = input_num[DATA_W-1];
            end
        end
    end

    // State and all registered outputs; reset also drops cpu_run immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q       <= S_LOAD;
            reg_we     <= 1'b0;
            reg_idx    <= '0;
            reg_wdata  <= '0;
            cpu_run    <= 1'b0;
            load_cnt   <= '0;
            run_cycles <= '0;
            timeout    <= 1'b0;
        end else begin
            st_q       <= st_n;
            reg_we     <= reg_we_n;
            reg_idx    <= reg_idx_n;
            reg_wdata  <= reg_wdata_n;
            cpu_run    <= cpu_run_n;
            load_cnt   <= load_cnt_n;
            run_cycles <= run_cycles_n;
            timeout    <= timeout_n;
        end
    end

    // Next-state and next-output decisions for the session sequence.
    always_comb begin
        st_n         = st_q;
        reg_we_n     = 1'b0;
        reg_idx_n    = reg_idx;
        reg_wdata_n  = reg_wdata;
        cpu_run_n    = cpu_run;
        load_cnt_n   = load_cnt;
        run_cycles_n = run_cycles;
        timeout_n    = timeout;
        case (st_q)
            S_LOAD: begin
                if (in_ev) begin
                    reg_we_n    = 1'b1;
                    reg_idx_n   = 5'(6'(FIRST_REG) + load_cnt);
                    reg_wdata_n = ext_data;
                    load_cnt_n  = load_cnt + 6'd1;
                    st_n        = S_HOLD;
                end
            end
            S_HOLD: begin
                // Full set goes straight to ARMED; otherwise wait for release so a held button writes once.
                if (load_cnt == 6'(NUM_ARGS)) begin
                    st_n = S_ARMED;
                end else if (!in_db) begin
                    st_n = S_LOAD;
                end
            end
            S_ARMED: begin
                if (start_ev) begin
                    run_cycles_n = '0;
                    cpu_run_n    = 1'b1;
                    st_n         = S_RUN;
                end
            end
            S_RUN: begin
                // Halt takes priority over the timeout in the same cycle.
                if (cpu_halt) begin
                    run_cycles_n = run_cycles + 1'b1;
                    cpu_run_n    = 1'b0;
                    timeout_n    = 1'b0;
                    st_n         = S_DONE;
                end else if (run_cycles == CYC_W'(MAX_CYC - 1)) begin
                    cpu_run_n = 1'b0;
                    timeout_n = 1'b1;
                    st_n      = S_DONE;
                end else begin
                    run_cycles_n = run_cycles + 1'b1;
                end
            end
            S_DONE: begin
                if (start_ev) begin
                    load_cnt_n = '0;
                    timeout_n  = 1'b0;
                    st_n       = S_LOAD;
                end
            end
            default: begin
                st_n = S_LOAD;
            end
        endcase
    end

    assign state = st_q;
endmodule

// File: tb/tb_cpu_preload_ctrl.sv
// tb/tb_cpu_preload_ctrl.sv - scoreboard bench for cpu_preload_ctrl
module tb_cpu_preload_ctrl;
    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        input_press, start_press, cpu_halt;
    logic [15:0] input_num;

    logic        reg_we_a, reg_we_b, cpu_run_a, cpu_run_b, timeout_a, timeout_b;
    logic [4:0]  reg_idx_a, reg_idx_b;
    logic [31:0] reg_wdata_a, reg_wdata_b, run_cycles_a, run_cycles_b;
    logic [2:0]  state_a, state_b;
    logic [5:0]  load_cnt_a, load_cnt_b;

    typedef struct { logic [4:0] idx; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] cyc; logic to; } dn_t;

    wr_t wq_a[$], wq_b[$];
    dn_t dq_a[$], dq_b[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] prev_a = 3'd0, prev_b = 3'd0;

    always #5 clk = ~clk;

    cpu_preload_ctrl dut_a (
        .clk(clk), .rst(rst_a), .input_press(input_press), .start_press(start_press),
        .input_num(input_num), .cpu_halt(cpu_halt), .reg_we(reg_we_a), .reg_idx(reg_idx_a),
        .reg_wdata(reg_wdata_a), .cpu_run(cpu_run_a), .state(state_a), .load_cnt(load_cnt_a),
        .run_cycles(run_cycles_a), .timeout(timeout_a)
    );

    cpu_preload_ctrl #(.SIGN_EXT(1), .MAX_CYC(50), .NUM_ARGS(1)) dut_b (
        .clk(clk), .rst(rst_b), .input_press(input_press), .start_press(start_press),
        .input_num(input_num), .cpu_halt(cpu_halt), .reg_we(reg_we_b), .reg_idx(reg_idx_b),
        .reg_wdata(reg_wdata_b), .cpu_run(cpu_run_b), .state(state_b), .load_cnt(load_cnt_b),
        .run_cycles(run_cycles_b), .timeout(timeout_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // which: 0 = expect write on A, 1 = expect write on B, 2 = expect no write
    task automatic press(input logic [15:0] val, input int which, input logic [4:0] idx, input logic [31:0] data);
        wr_t w;
        w.idx  = idx;
        w.data = data;
        if (which == 0) wq_a.push_back(w);
        if (which == 1) wq_b.push_back(w);
        input_num   = val;
        input_press = 1'b1;
        step(8);
        input_press = 1'b0;
        step(8);
    endtask

    task automatic restart();
        start_press = 1'b1;
        step(8);
        start_press = 1'b0;
        step(8);
    endtask

    task automatic start_run(input int which, output int lat);
        lat = 31;
        start_press = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            if ((which == 0 && cpu_run_a) || (which == 1 && cpu_run_b)) begin
                lat = i;
                break;
            end
        end
        start_press = 1'b0;
    endtask

    task automatic push_done(input int which, input logic [31:0] cyc, input logic to);
        dn_t d;
        d.cyc = cyc;
        d.to  = to;
        if (which == 0) dq_a.push_back(d); else dq_b.push_back(d);
    endtask

    // Monitor for DUT A: writes and DONE entries are checked against the queues.
    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        if (reg_we_a) begin
            if (wq_a.size() == 0) begin
                check("a_unexpected_write", 1, 0);
            end else begin
                w = wq_a.pop_front();
                check("a_reg_idx", reg_idx_a, w.idx);
                check("a_reg_wdata", reg_wdata_a, w.data);
            end
        end
        if (state_a == 3'd4 && prev_a != 3'd4) begin
            if (dq_a.size() == 0) begin
                check("a_unexpected_done", 1, 0);
            end else begin
                d = dq_a.pop_front();
                check("a_run_cycles", run_cycles_a, d.cyc);
                check("a_timeout", timeout_a, d.to);
            end
        end
        prev_a = state_a;
    end

    // Monitor for DUT B.
    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        if (reg_we_b) begin
            if (wq_b.size() == 0) begin
                check("b_unexpected_write", 1, 0);
            end else begin
                w = wq_b.pop_front();
                check("b_reg_idx", reg_idx_b, w.idx);
                check("b_reg_wdata", reg_wdata_b, w.data);
            end
        end
        if (state_b == 3'd4 && prev_b != 3'd4) begin
            if (dq_b.size() == 0) begin
                check("b_unexpected_done", 1, 0);
            end else begin
                d = dq_b.pop_front();
                check("b_run_cycles", run_cycles_b, d.cyc);
                check("b_timeout", timeout_b, d.to);
            end
        end
        prev_b = state_b;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int first;
        int lat;
        wr_t w;
        rst_a = 1'b0; rst_b = 1'b0;
        input_press = 1'b0; start_press = 1'b0; cpu_halt = 1'b0; input_num = '0;
        step(3);
        check("rst_state", state_a, 0);
        check("rst_load_cnt", load_cnt_a, 0);
        check("rst_reg_we", reg_we_a, 0);
        check("rst_reg_idx", reg_idx_a, 0);
        check("rst_reg_wdata", reg_wdata_a, 0);
        check("rst_cpu_run", cpu_run_a, 0);
        check("rst_run_cycles", run_cycles_a, 0);
        check("rst_timeout", timeout_a, 0);
        rst_a = 1'b1;
        step(2);

        // Held press: one write on the 6th edge, stays in HOLD until release.
        w.idx = 5'd4; w.data = 32'h0000_8001; wq_a.push_back(w);
        input_num = 16'h8001;
        input_press = 1'b1;
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (reg_we_a && first == 0) first = i;
        end
        check("press_latency", first, 6);
        check("hold_state", state_a, 1);
        check("hold_load_cnt", load_cnt_a, 1);
        input_press = 1'b0;
        step(8);
        check("release_state", state_a, 0);

        // Two-cycle glitch must not write.
        input_press = 1'b1;
        step(2);
        input_press = 1'b0;
        step(10);
        check("glitch_load_cnt", load_cnt_a, 1);

        press(16'hFFFE, 0, 5'd5, 32'h0000_FFFE);
        press(16'h0002, 0, 5'd6, 32'h0000_0002);
        press(16'h0003, 0, 5'd7, 32'h0000_0003);
        check("armed_state", state_a, 2);
        check("armed_load_cnt", load_cnt_a, 4);
        press(16'h1234, 2, 5'd0, 32'h0);
        check("armed_ignore_input", load_cnt_a, 4);

        // Halt 100 cycles after cpu_run.
        push_done(0, 32'd100, 1'b0);
        start_run(0, lat);
        check("start_latency", lat, 6);
        check("run_state", state_a, 3);
        check("run_cycles_start", run_cycles_a, 0);
        step(99);
        cpu_halt = 1'b1;
        step(1);
        check("done_state", state_a, 4);
        check("done_cpu_run", cpu_run_a, 0);
        cpu_halt = 1'b0;
        step(10);
        check("done_frozen_cycles", run_cycles_a, 100);
        check("done_frozen_timeout", timeout_a, 0);
        restart();
        check("restart_state", state_a, 0);
        check("restart_load_cnt", load_cnt_a, 0);

        // Reset in the middle of RUN.
        press(16'h0011, 0, 5'd4, 32'h11);
        press(16'h0022, 0, 5'd5, 32'h22);
        press(16'h0033, 0, 5'd6, 32'h33);
        press(16'h0044, 0, 5'd7, 32'h44);
        start_run(0, lat);
        step(20);
        check("midrun_cycles", run_cycles_a, 20);
        #2 rst_a = 1'b0;
        #1;
        check("mr_cpu_run", cpu_run_a, 0);
        check("mr_state", state_a, 0);
        check("mr_load_cnt", load_cnt_a, 0);
        check("mr_reg_idx", reg_idx_a, 0);
        check("mr_reg_wdata", reg_wdata_a, 0);
        check("mr_run_cycles", run_cycles_a, 0);
        step(2);
        rst_a = 1'b1;
        step(20);
        check("mr_after_state", state_a, 0);
        rst_a = 1'b0;

        // DUT B: sign extension, single operand, MAX_CYC = 50.
        rst_b = 1'b1;
        step(2);
        w.idx = 5'd4; w.data = 32'hFFFF_FFFE; wq_b.push_back(w);
        input_num = 16'hFFFE;
        input_press = 1'b1;
        step(8);
        check("b_armed_while_held", state_b, 2);
        check("b_load_cnt", load_cnt_b, 1);
        input_press = 1'b0;
        step(8);

        push_done(1, 32'd49, 1'b1);
        start_run(1, lat);
        check("b_start_latency", lat, 6);
        for (int i = 0; i < 100 && state_b != 3'd4; i++) step(1);
        check("b_timeout_state", state_b, 4);
        check("b_timeout_flag", timeout_b, 1);
        check("b_timeout_cpu_run", cpu_run_b, 0);
        restart();
        check("b_restart_timeout", timeout_b, 0);
        check("b_restart_state", state_b, 0);

        // Halt coinciding with the timeout cycle: halt wins.
        press(16'h0007, 1, 5'd4, 32'h7);
        push_done(1, 32'd50, 1'b0);
        start_run(1, lat);
        step(49);
        cpu_halt = 1'b1;
        step(1);
        check("b_halt_wins_state", state_b, 4);
        check("b_halt_wins_timeout", timeout_b, 0);
        cpu_halt = 1'b0;
        restart();

        // Halt already high on entering RUN.
        press(16'h8000, 1, 5'd4, 32'hFFFF_8000);
        cpu_halt = 1'b1;
        push_done(1, 32'd1, 1'b0);
        start_run(1, lat);
        step(1);
        check("b_early_halt_state", state_b, 4);
        check("b_early_halt_cycles", run_cycles_b, 1);
        cpu_halt = 1'b0;
        step(5);

        check("wq_a_empty", wq_a.size(), 0);
        check("wq_b_empty", wq_b.size(), 0);
        check("dq_a_empty", dq_a.size(), 0);
        check("dq_b_empty", dq_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
